// File: rtl/imcin_gen.sv
// Raster-to-2x2-block packer: buffers even rows in a half-line memory and
// emits one packed block per odd-row, odd-column pixel.
module imcin_gen #(
    parameter  int DW_IN = 10,
    parameter  int IMG_W = 1920,
    parameter  int IMG_H = 1080,
    localparam int XW    = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1,
    localparam int YW    = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sof,
    input  logic               pix_vld,
    input  logic [DW_IN-1:0]   pix_in,
    output logic [4*DW_IN-1:0] imcin,
    output logic               imoy_calc_en,
    output logic [XW-1:0]      blk_x,
    output logic [YW-1:0]      blk_y,
    output logic               frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]        col;
    logic [CW-1:0]        c_eff;
    logic [RW-1:0]        row;
    logic [RW-1:0]        r_eff;
    logic [DW_IN-1:0]     left_q;
    logic [XW-1:0]        addr;
    logic                 c_last;
    logic                 r_last;
    logic                 wr_en;
    logic                 rd_en;
    logic [2*DW_IN-1:0]   rd_data;
    logic [2*DW_IN-1:0]   lbuf [IMG_W/2];

    // sof restarts the raster at (0,0) for the pixel arriving with it
    assign c_eff   = sof ? '0 : col;
    assign r_eff   = sof ? '0 : row;
    assign addr    = XW'(c_eff >> 1);
    assign c_last  = (c_eff == CW'(IMG_W - 1));
    assign r_last  = (r_eff == RW'(IMG_H - 1));
    assign wr_en   = pix_vld & c_eff[0] & ~r_eff[0];
    assign rd_en   = pix_vld & c_eff[0] & r_eff[0];
    assign rd_data = lbuf[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lbuf[addr] <= {left_q, pix_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            row          <= '0;
            left_q       <= '0;
            imcin        <= '0;
            blk_x        <= '0;
            blk_y        <= '0;
            imoy_calc_en <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            imoy_calc_en <= 1'b0;
            frame_done   <= 1'b0;
            if (sof) begin
                col <= '0;
                row <= '0;
            end
            if (pix_vld) begin
                col <= c_last ? '0 : c_eff + 1'b1;
                if (c_last) begin
                    row <= r_last ? '0 : r_eff + 1'b1;
                end else begin
                    row <= r_eff;
                end
                if (!c_eff[0]) begin
                    left_q <= pix_in;
                end
                if (rd_en) begin
                    imcin        <= {rd_data, left_q, pix_in};
                    blk_x        <= addr;
                    blk_y        <= YW'(r_eff >> 1);
                    imoy_calc_en <= 1'b1;
                    frame_done   <= c_last & r_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_imcin_gen.sv
// Bench for imcin_gen: a 4x2 and a 4x4 instance share one pixel stream and
// are checked every cycle against a raster image model plus literal blocks.
module tb_imcin_gen;

    localparam int W = 4;

    typedef struct {
        logic [39:0] blk;
        int          bx;
        int          by;
        bit          fd;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        pix_vld = 1'b0;
    logic [9:0]  pix_in = '0;

    logic [39:0] imcin_a, imcin_b;
    logic        en_a, en_b, fd_a, fd_b;
    logic [0:0]  bx_a, by_a, bx_b, by_b;

    int          vectors = 0;
    int          errs = 0;
    int          edge_n = 0;
    int          hh [2] = '{2, 4};
    int          pr [2];
    int          pc [2];
    logic [9:0]  img [2][4][4];
    logic [39:0] last [2];
    exp_t        q [2][$];

    imcin_gen #(.DW_IN(10), .IMG_W(4), .IMG_H(2)) u_a (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_vld(pix_vld),
        .pix_in(pix_in), .imcin(imcin_a), .imoy_calc_en(en_a),
        .blk_x(bx_a), .blk_y(by_a), .frame_done(fd_a)
    );

    imcin_gen #(.DW_IN(10), .IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_vld(pix_vld),
        .pix_in(pix_in), .imcin(imcin_b), .imoy_calc_en(en_b),
        .blk_x(bx_b), .blk_y(by_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Per-cycle compare of both instances against the image model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic [39:0] g_blk;
                logic        g_en, g_fd;
                int          g_bx, g_by;
                exp_t        e;
                g_blk = (k == 0) ? imcin_a : imcin_b;
                g_en  = (k == 0) ? en_a : en_b;
                g_fd  = (k == 0) ? fd_a : fd_b;
                g_bx  = (k == 0) ? int'(bx_a) : int'(bx_b);
                g_by  = (k == 0) ? int'(by_a) : int'(by_b);
                vectors++;
                if (q[k].size() > 0 && q[k][0].due == edge_n) begin
                    e = q[k].pop_front();
                    if (!(g_en && g_blk == e.blk && g_bx == e.bx &&
                          g_by == e.by && g_fd == e.fd)) begin
                        errs++;
                        $display("FAIL strobe[%0d] t=%0t got en=%b blk=%h x=%0d y=%0d fd=%b want en=1 blk=%h x=%0d y=%0d fd=%b",
                                 k, $time, g_en, g_blk, g_bx, g_by, g_fd,
                                 e.blk, e.bx, e.by, e.fd);
                    end
                    last[k] = e.blk;
                end else if (g_en || g_fd || g_blk != last[k]) begin
                    errs++;
                    $display("FAIL idle[%0d] t=%0t got en=%b fd=%b blk=%h want en=0 fd=0 blk=%h",
                             k, $time, g_en, g_fd, g_blk, last[k]);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [39:0] got,
                       input logic [39:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            pr[k] = 0;
            pc[k] = 0;
            q[k].delete();
            last[k] = '0;
        end
    endtask

    task automatic send(input logic v, input logic s, input logic [9:0] d);
        exp_t e;
        @(negedge clk);
        sof = s;
        pix_vld = v;
        pix_in = d;
        for (int k = 0; k < 2; k++) begin
            if (s) begin
                pr[k] = 0;
                pc[k] = 0;
            end
            if (v) begin
                img[k][pr[k]][pc[k]] = d;
                if (pr[k] % 2 == 1 && pc[k] % 2 == 1) begin
                    e.blk = {img[k][pr[k]-1][pc[k]-1], img[k][pr[k]-1][pc[k]],
                             img[k][pr[k]][pc[k]-1], d};
                    e.bx  = pc[k] / 2;
                    e.by  = pr[k] / 2;
                    e.fd  = (pc[k] == W - 1) && (pr[k] == hh[k] - 1);
                    e.due = edge_n + 1;
                    q[k].push_back(e);
                end
                pc[k]++;
                if (pc[k] == W) begin
                    pc[k] = 0;
                    pr[k] = (pr[k] + 1) % hh[k];
                end
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        lit({nm, "_imcin_a"}, imcin_a, 40'd0);
        lit({nm, "_imcin_b"}, imcin_b, 40'd0);
        lit({nm, "_ctl"}, {34'd0, en_a, en_b, fd_a, fd_b, bx_b, by_b}, 40'd0);
    endtask

    logic [39:0] blk;
    int          avg;

    initial begin
        model_clear();
        #12;
        check_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Minimal 4x2 frame, continuous valid
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, i == 1, 10'(i));
            if (i == 6) begin
                after_edge();
                lit("min_blk0", imcin_a, {10'd1, 10'd2, 10'd5, 10'd6});
                lit("min_en0", {39'd0, en_a}, 40'd1);
            end
            if (i == 8) begin
                after_edge();
                lit("min_blk1", imcin_a, {10'd3, 10'd4, 10'd7, 10'd8});
                lit("min_fd1", {38'd0, bx_a, fd_a}, 40'd3);
            end
        end

        // Gapped valid
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, i == 1, 10'(i));
            if (i == 6) begin
                after_edge();
                lit("gap_blk0", imcin_a, {10'd1, 10'd2, 10'd5, 10'd6});
            end
            for (int g = 0; g < 3; g++) send(1'b0, 1'b0, 10'h3ff);
        end

        // Mid-frame sof on the 4x4 instance
        for (int i = 1; i <= 5; i++) send(1'b1, i == 1, 10'(i));
        for (int i = 0; i < 16; i++) begin
            send(1'b1, i == 0, 10'(100 + i));
            if (i == 5) begin
                after_edge();
                lit("sof_blk0", imcin_b, {10'd100, 10'd101, 10'd104, 10'd105});
                lit("sof_by0", {39'd0, by_b}, 40'd0);
            end
        end

        // Back-to-back 4x4 frames without sof between them
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, 10'(20 + i));
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, 10'(200 + i));
        after_edge();
        lit("b2b_blk11", imcin_b, {10'd210, 10'd211, 10'd214, 10'd215});
        lit("b2b_fd", {38'd0, fd_b, by_b}, 40'd3);

        // Async reset between the odd-row even and odd pixels
        for (int i = 1; i <= 5; i++) send(1'b1, i == 1, 10'(i));
        @(negedge clk);
        pix_vld = 1'b0;
        sof = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("areset");
        model_clear();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 1'b0, 10'(i));
            if (i == 6) begin
                after_edge();
                lit("rst_blk0", imcin_a, {10'd1, 10'd2, 10'd5, 10'd6});
            end
            if (i == 8) begin
                after_edge();
                lit("rst_blk1", imcin_a, {10'd3, 10'd4, 10'd7, 10'd8});
            end
        end

        // Near-full-scale block feeding a rounding 4-pixel average
        send(1'b1, 1'b1, 10'd1023);
        send(1'b1, 1'b0, 10'd1023);
        send(1'b1, 1'b0, 10'd0);
        send(1'b1, 1'b0, 10'd0);
        send(1'b1, 1'b0, 10'd1023);
        send(1'b1, 1'b0, 10'd1022);
        after_edge();
        blk = imcin_a;
        lit("chain_blk", blk, {10'd1023, 10'd1023, 10'd1023, 10'd1022});
        avg = (int'(blk[39:30]) + int'(blk[29:20]) + int'(blk[19:10]) +
               int'(blk[9:0]) + 2) >> 2;
        lit("chain_avg", 40'(avg), 40'd1023);
        send(1'b1, 1'b0, 10'd0);
        send(1'b1, 1'b0, 10'd0);

        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 10'd0);
        lit("pending", 40'(q[0].size() + q[1].size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/imcin_gen.md
# imcin_gen

Raster-to-block packer for the over-exposure correction path. It accepts one pixel per valid cycle in raster order and buffers each even row in a half-line memory. On every odd-row, odd-column pixel it emits one packed 2x2 block plus a one-cycle enable. These feed the 4-pixel averager's `imcin` and `imoy_calc_en` inputs directly.

## Interface
Parameters:
- `DW_IN`, 10 — pixel width.
- `IMG_W`, 1920 — pixels per line. Must be even and ≥2.
- `IMG_H`, 1080 — lines per frame. Must be even and ≥2.

Ports:
- `clk`  in  1  — sole clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `sof`  in  1  — start-of-frame pulse. Synchronous restart of position counters.
- `pix_vld`  in  1  — `pix_in` valid this cycle. No backpressure.
- `pix_in`  in  DW_IN  — raster pixel.
- `imcin`  out  4*DW_IN  — packed block: [4DW-1:3DW]=top-left, [3DW-1:2DW]=top-right, [2DW-1:DW]=bottom-left, [DW-1:0]=bottom-right.
- `imoy_calc_en`  out  1  — one-cycle strobe, `imcin` valid.
- `blk_x`  out  $clog2(IMG_W/2)  — block column of current `imcin`.
- `blk_y`  out  $clog2(IMG_H/2)  — block row of current `imcin`.
- `frame_done`  out  1  — pulses with the enable of the last block of the frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `pix_vld`. Idle cycles hold all state.
- `col` wraps to 0 at IMG_W-1 and increments `row`. `row` wraps to 0 after IMG_H-1. There is no overflow state; the next frame starts at (0,0).
- `sof` clears `col`/`row` to 0.
  - `sof` with `pix_vld` in the same cycle: the pixel is taken as (0,0).
  - `sof` mid-frame: the partial frame is abandoned. Line-buffer contents are stale but are fully overwritten before reuse.
- Even row:
  - Even col: `pix_in` is held in `left_q`.
  - Odd col: {`left_q`, `pix_in`} is written to line buffer address col>>1.
  - Line buffer: IMG_W/2 entries x 2*DW_IN. No reset.
- Odd row:
  - Even col: `pix_in` is held in `left_q`.
  - Odd col: read address col>>1. Register `imcin` = {buf_hi, buf_lo, `left_q`, `pix_in`}, `blk_x`=col>>1, `blk_y`=row>>1, and `imoy_calc_en`=1 for exactly one cycle.
- The read of an address on an odd row never collides with its write, because writes occur only on even rows. Read is combinational or registered as the implementation chooses, provided the latency below holds.
- `frame_done` = `imoy_calc_en` && `blk_x`==IMG_W/2-1 && `blk_y`==IMG_H/2-1.
- Pixel data is passed unmodified. There is no arithmetic on pixel values.

## Timing
- Reset values:
  - `imcin`, `blk_x`, `blk_y`: 0.
  - `imoy_calc_en`, `frame_done`: 0.
  - `col`, `row`, `left_q`: 0.
- Latency: `imoy_calc_en` rises exactly 1 cycle after the clock edge that accepts the odd-row, odd-col pixel.
- `imcin` holds its value between strobes.
- The downstream averager registers pair sums on the `imoy_calc_en` cycle and presents `imoy` 2 cycles after the strobe. The end-to-end latency is 3 cycles from the last pixel of a block.
- Maximum strobe rate: one every 2 cycles. Strobes occur only on odd rows, so each frame produces IMG_W/2 * IMG_H/2 strobes.
- Reset asserted mid-frame: all outputs and counters go to reset values immediately. The first pixel after release is (0,0) with or without `sof`.

## Test plan
- Minimal frame, IMG_W=4, IMG_H=2, continuous `pix_vld`:
  - Stimulus: pixels 1..8.
  - Response: strobe 1 has `imcin`={1,2,5,6}, `blk_x`=0. Strobe 2 has {3,4,7,8}, `blk_x`=1, `frame_done`=1. Exactly 2 strobes, each 1 cycle after pixels 6 and 8.
- Gapped valid, IMG_W=4, IMG_H=2:
  - Stimulus: insert 3 idle cycles between every pixel.
  - Response: same `imcin` values as the minimal-frame case. The strobe is 1 cycle after the accepting edge. `imcin` stays stable during gaps.
- Mid-frame `sof`, IMG_W=4, IMG_H=4:
  - Stimulus: assert `sof` with pixel 6, then stream 16 new pixels 100..115.
  - Response: the first strobe is {100,101,104,105} with `blk_y`=0. There are no strobes from the abandoned data.
- Back-to-back frames, IMG_W=4, IMG_H=4, no `sof` between them:
  - Response: 4 strobes per frame. `frame_done` on strobe 4 of each frame. Block (1,1) of frame 2 = {pixels 10,11,14,15 of frame 2}.
- Async reset:
  - Stimulus: pull `rst_n` low between the odd-row even and odd pixels.
  - Response: all outputs 0 asynchronously. After release, a full 4x2 frame gives {1,2,5,6},{3,4,7,8}.
- Chained with the averager, DW_IN=10:
  - Stimulus: block {1023,1023,1023,1022}.
  - Response: `imoy`=1023 three cycles after the last pixel.
